// File: rtl/matrix_scan_controller.sv
// matrix_scan_controller: scans a 64-bit frame onto an 8x8 LED matrix through an external column shift register
//   clk          system clock
//   rst          synchronous active-low reset
//   frame_in     frame word, row r = frame_in[8r+7:8r], bit 7 = column 7
//   frame_valid  source has a frame (held stable until frame_ack)
//   frame_ack    one-cycle pulse: frame_in captured
//   sr_data      serial column data, MSB first
//   sr_clk       column shift clock
//   sr_latch     one-cycle column storage strobe
//   row_sel      one-hot active-high row enable
//   frame_start  one-cycle pulse for the row 0 load
module matrix_scan_controller #(
    parameter int DWELL_CYCLES = 1000,
    parameter int CLK_DIV      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] frame_in,
    input  logic        frame_valid,
    output logic        frame_ack,
    output logic        sr_data,
    output logic        sr_clk,
    output logic        sr_latch,
    output logic [7:0]  row_sel,
    output logic        frame_start
);
    localparam int MAXC = DWELL_CYCLES > 16 * CLK_DIV ? DWELL_CYCLES : 16 * CLK_DIV;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, DISPLAY} state_t;

    state_t        state;
    logic [2:0]    row;
    logic [2:0]    bits;
    logic [7:0]    sreg;
    logic [63:0]   frame;
    logic          ph;
    logic [CW-1:0] cnt;
    logic          div_end;
    logic          dwell_end;

    assign div_end   = cnt == CW'(CLK_DIV - 1);
    assign dwell_end = cnt == CW'(DWELL_CYCLES - 1);

    // Outputs are registered from the current state, so the pins show each
    // state one cycle after it is entered; sr_data therefore changes exactly
    // when sr_clk falls and stays put across the whole high phase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            row         <= 3'd0;
            bits        <= 3'd0;
            sreg        <= 8'd0;
            frame       <= 64'd0;
            ph          <= 1'b0;
            cnt         <= '0;
            frame_ack   <= 1'b0;
            sr_data     <= 1'b0;
            sr_clk      <= 1'b0;
            sr_latch    <= 1'b0;
            row_sel     <= 8'd0;
            frame_start <= 1'b0;
        end else begin
            frame_ack   <= 1'b0;
            sr_data     <= state == SHIFT && sreg[7];
            sr_clk      <= state == SHIFT && ph;
            sr_latch    <= state == LATCH;
            row_sel     <= state == DISPLAY ? 8'd1 << row : 8'd0;
            frame_start <= state == LOAD && row == 3'd0;
            case (state)
                IDLE: if (frame_valid) begin
                    frame     <= frame_in;
                    row       <= 3'd0;
                    frame_ack <= 1'b1;
                    state     <= LOAD;
                end
                LOAD: begin
                    sreg  <= frame[{row, 3'b000} +: 8];
                    cnt   <= '0;
                    ph    <= 1'b0;
                    bits  <= 3'd0;
                    state <= SHIFT;
                end
                SHIFT: if (div_end) begin
                    cnt <= '0;
                    ph  <= ~ph;
                    // end of a high phase is the falling edge: advance to the next bit
                    if (ph) begin
                        sreg <= sreg << 1;
                        bits <= bits + 3'd1;
                        if (bits == 3'd7) state <= LATCH;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
                LATCH: begin
                    cnt   <= '0;
                    state <= DISPLAY;
                end
                DISPLAY: if (dwell_end) begin
                    cnt   <= '0;
                    row   <= row == 3'd7 ? 3'd0 : row + 3'd1;
                    state <= LOAD;
                    // only the end of row 7 is a frame boundary where a new frame may enter
                    if (row == 3'd7 && frame_valid) begin
                        frame     <= frame_in;
                        frame_ack <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_scan_controller.sv
// tb_matrix_scan_controller: randomized self-checking bench with a position-based scan model
module tb_matrix_scan_controller;
    localparam int DW = 4;
    localparam int CD = 2;
    localparam int P  = 2 + 16 * CD + DW;
    localparam int F  = 8 * P;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fv  = 1'b0;
    logic [63:0] fin = 64'd0;
    logic        frame_ack, sr_data, sr_clk, sr_latch, frame_start;
    logic [7:0]  row_sel;

    int total = 0;
    int bad   = 0;

    matrix_scan_controller #(.DWELL_CYCLES(DW), .CLK_DIV(CD)) dut (
        .clk(clk), .rst(rst), .frame_in(fin), .frame_valid(fv),
        .frame_ack(frame_ack), .sr_data(sr_data), .sr_clk(sr_clk),
        .sr_latch(sr_latch), .row_sel(row_sel), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: position within the frame's output timeline; pos 0 is the cycle
    // frame_start is visible, pos -1 the ack cycle after an idle capture.
    logic        m_idle = 1'b1;
    logic        m_arm  = 1'b0;
    logic        m_ack  = 1'b0;
    logic [63:0] mbuf   = 64'd0;
    int          pos    = 0;

    always @(posedge clk) begin
        if (!rst) begin
            m_idle = 1'b1;
            m_arm  = 1'b1;
            m_ack  = 1'b0;
            mbuf   = 64'd0;
            pos    = 0;
        end else if (m_idle) begin
            m_ack = fv;
            if (fv) begin
                mbuf   = fin;
                m_idle = 1'b0;
                pos    = -1;
            end
        end else begin
            m_ack = fv && pos == F - 2;
            if (m_ack) mbuf = fin;
            pos = (pos + 1) % F;
        end
    end

    logic pck = 1'b0;
    always @(negedge clk) if (m_arm) begin
        logic [7:0] e_rs;
        logic e_fs, e_lat, e_ck, e_d;
        int r, q, k;
        e_rs = 8'd0; e_fs = 1'b0; e_lat = 1'b0; e_ck = 1'b0; e_d = 1'b0;
        if (!m_idle && pos >= 0) begin
            r = pos / P;
            q = pos % P;
            if (q == 0) e_fs = r == 0;
            else if (q <= 16 * CD) begin
                k    = q - 1;
                e_ck = (k % (2 * CD)) >= CD;
                e_d  = mbuf[8 * r + 7 - k / (2 * CD)];
            end else if (q == 16 * CD + 1) e_lat = 1'b1;
            else e_rs = 8'd1 << r;
        end
        chk("frame_ack", frame_ack, m_ack);
        chk("frame_start", frame_start, e_fs);
        chk("sr_latch", sr_latch, e_lat);
        chk("sr_clk", sr_clk, e_ck);
        chk("sr_data", sr_data, e_d);
        chk("row_sel", row_sel, e_rs);
        chk("onehot", $countones(row_sel) <= 1, 1);
        if (sr_latch || sr_clk !== pck) chk("blanking", row_sel, 0);
        pck = sr_clk;
    end

    // Observer: rebuilds shifted bytes and per-frame serial streams from the pins
    logic        prev_ck = 1'b0;
    logic        was_on  = 1'b0;
    logic [7:0]  sh = 8'd0;
    logic [7:0]  lat = 8'd0;
    logic [7:0]  disp [8];
    logic [63:0] acc = 64'd0;
    logic [63:0] last_stream = 64'd0;

    always begin
        @(posedge clk);
        #1;
        if (sr_clk === 1'b1 && !prev_ck) begin
            sh  = {sh[6:0], sr_data};
            acc = {acc[62:0], sr_data};
        end
        prev_ck = sr_clk === 1'b1;
        if (sr_latch === 1'b1) lat = sh;
        if (row_sel !== 8'd0 && !was_on)
            for (int r = 0; r < 8; r++) if (row_sel[r] === 1'b1) disp[r] = lat;
        was_on = row_sel !== 8'd0;
        if (frame_start === 1'b1) begin
            last_stream = acc;
            acc = 64'd0;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ack(input int n);
        int i = 0;
        do begin tick(); i++; end while (frame_ack !== 1'b1 && i < n);
        chk("ack_seen", frame_ack, 1);
    endtask

    task automatic wait_fs(input int n, output int cnt);
        cnt = 0;
        do begin tick(); cnt++; end while (frame_start !== 1'b1 && cnt < n);
        chk("fs_seen", frame_start, 1);
    endtask

    task automatic wait_row(input logic [7:0] v, input int n);
        int i = 0;
        do begin tick(); i++; end while (row_sel !== v && i < n);
        chk("row_seen", row_sel, v);
    endtask

    initial begin
        int n;
        for (int r = 0; r < 8; r++) disp[r] = 8'd0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (50) tick();
        chk("idle_quiet", {frame_ack, sr_data, sr_clk, sr_latch, row_sel, frame_start}, 0);

        fin = 64'h3C3C1C1818080808;
        fv  = 1'b1;
        wait_ack(10);
        chk("ack_before_start", frame_start, 0);
        fv = 1'b0;
        tick();
        chk("ack_one_cycle", frame_ack, 0);
        chk("start_after_ack", frame_start, 1);
        repeat (34) tick();
        for (int i = 0; i < 4; i++) begin
            chk("row0_on", row_sel, 8'h01);
            tick();
        end
        chk("row0_off", row_sel, 8'h00);
        wait_fs(400, n);
        chk("frame_period", n, F - P);
        chk("row0_byte", disp[0], 8'h08);
        chk("row7_byte", disp[7], 8'h3C);
        chk("stream1", last_stream, 64'h08080818181C3C3C);
        wait_fs(400, n);
        chk("stream2", last_stream, 64'h08080818181C3C3C);
        wait_fs(400, n);
        chk("stream3", last_stream, 64'h08080818181C3C3C);

        wait_row(8'h08, 400);
        fin = 64'hFF00FF00FF00FF00;
        fv  = 1'b1;
        wait_ack(400);
        chk("ack_at_row7", row_sel, 8'h80);
        chk("old_row4", disp[4], 8'h18);
        chk("old_row5", disp[5], 8'h1C);
        chk("old_row6", disp[6], 8'h3C);
        chk("old_row7", disp[7], 8'h3C);
        fv = 1'b0;
        wait_fs(10, n);
        wait_fs(400, n);
        chk("new_row0", disp[0], 8'h00);
        chk("new_row1", disp[1], 8'hFF);
        chk("new_stream", last_stream, 64'h00FF00FF00FF00FF);

        repeat (2 * P + 18) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("reset_clears", {frame_ack, sr_data, sr_clk, sr_latch, row_sel, frame_start}, 0);
        repeat (40) tick();
        chk("reset_stays_idle", {frame_ack, sr_data, sr_clk, sr_latch, row_sel, frame_start}, 0);
        fin = {$urandom, $urandom};
        fv  = 1'b1;
        wait_ack(10);
        fv = 1'b0;
        tick();
        chk("restart_row0", frame_start, 1);

        repeat (6) begin
            n = $urandom_range(0, 400);
            repeat (n) begin
                fin = {$urandom, $urandom};
                tick();
            end
            if ($urandom_range(0, 3) == 0) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end
            fin = {$urandom, $urandom};
            fv  = 1'b1;
            wait_ack(F + 10);
            fv = 1'b0;
        end
        repeat (F + 20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
